logic_cmd_issuer: RTL and testbench

Initiator-side companion to the combinational logic_engine (opcodes: 00 OR, 01 NAND, 10 NOR, 11 AND).
- Accepts operand/opcode commands over a valid/ready stream and buffers them in a small FIFO.
- Drives the engine's A/B/opcode inputs from registers and samples its result after a fixed latency.
- Returns each result on a valid/ready response stream.
- Supports chaining, where the previous result replaces operand A, so multi-step logic expressions run without host round-trips.

---
 rtl/logic_engine_pkg.sv | 25 ++
 rtl/logic_cmd_fifo.sv | 54 +++++
 rtl/logic_engine.sv | 25 ++
 rtl/logic_cmd_issuer.sv | 141 ++++++++++++++
 tb/tb_logic_cmd_issuer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_engine_pkg.sv
// Shared opcodes, FSM state encoding and command layout for the logic engine
// command issuer and its companion combinational engine.
package logic_engine_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic                 chain;
    logic [1:0]           opcode;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } cmd_t;

endpackage

// File: rtl/logic_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without an occupancy counter.
module logic_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/logic_engine.sv
// Combinational bitwise logic engine: OR, NAND, NOR, AND selected by opcode.
module logic_engine
  import logic_engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  output logic [WIDTH-1:0] result
);

  // opcode decode
  always_comb begin
    result = '0;
    case (opcode)
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_cmd_issuer.sv
// Buffers logic commands, drives the combinational engine from registers,
// samples its result after ENG_LAT cycles and returns it on a response stream.
module logic_cmd_issuer
  import logic_engine_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int ENG_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_opcode,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic [1:0]       eng_opcode,
  input  logic [WIDTH-1:0] eng_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_opcode,
  output logic             busy
);

  localparam int         CMD_W = 2 * WIDTH + 3;
  localparam logic [3:0] LAT   = 4'(ENG_LAT);

  state_t           state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] eng_a_next, eng_b_next, rsp_data_next;
  logic [1:0]       eng_opcode_next, rsp_opcode_next;
  logic             rsp_valid_next;

  logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, push, pop;
  logic             head_chain;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;

  assign cmd_ready  = !fifo_full && !rst;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign busy       = !fifo_empty || (state != IDLE);
  assign fifo_wdata = {cmd_chain, cmd_opcode, cmd_a, cmd_b};
  assign {head_chain, head_op, head_a, head_b} = fifo_rdata;

  logic_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // next-state and next-register values; everything holds unless updated
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    acc_next        = acc;
    eng_a_next      = eng_a;
    eng_b_next      = eng_b;
    eng_opcode_next = eng_opcode;
    rsp_data_next   = rsp_data;
    rsp_opcode_next = rsp_opcode;
    rsp_valid_next  = rsp_valid;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          eng_a_next      = head_chain ? acc : head_a;
          eng_b_next      = head_b;
          eng_opcode_next = head_op;
          cnt_next        = LAT;
          state_next      = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          rsp_data_next   = eng_result;
          acc_next        = eng_result;
          rsp_opcode_next = eng_opcode;
          rsp_valid_next  = 1'b1;
          cnt_next        = 4'd0;
          state_next      = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      acc        <= '0;
      eng_a      <= '0;
      eng_b      <= '0;
      eng_opcode <= 2'b00;
      rsp_data   <= '0;
      rsp_opcode <= 2'b00;
      rsp_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      acc        <= acc_next;
      eng_a      <= eng_a_next;
      eng_b      <= eng_b_next;
      eng_opcode <= eng_opcode_next;
      rsp_data   <= rsp_data_next;
      rsp_opcode <= rsp_opcode_next;
      rsp_valid  <= rsp_valid_next;
    end
  end

endmodule

// File: tb/tb_logic_cmd_issuer.sv
// Random and directed stimulus for logic_cmd_issuer against a queue-based
// reference model; one instance with a 1-cycle engine, one with a 3-cycle engine.
module tb_logic_cmd_issuer;
  import logic_engine_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         c1_valid, c1_ready, c1_chain, r1_valid, r1_ready, busy1;
  logic [W-1:0] c1_a, c1_b, e1_a, e1_b, e1_res, r1_data;
  logic [1:0]   c1_op, e1_op, r1_op;
  logic         c3_valid, c3_ready, c3_chain, r3_valid, r3_ready, busy3;
  logic [W-1:0] c3_a, c3_b, e3_a, e3_b, e3_comb, pipe3, e3_res, r3_data;
  logic [1:0]   c3_op, e3_op, r3_op;

  logic_cmd_issuer #(.WIDTH(W), .FIFO_DEPTH(4), .ENG_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_a(c1_a), .cmd_b(c1_b), .cmd_opcode(c1_op), .cmd_chain(c1_chain),
    .eng_a(e1_a), .eng_b(e1_b), .eng_opcode(e1_op), .eng_result(e1_res),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data),
    .rsp_opcode(r1_op), .busy(busy1));
  logic_engine #(.WIDTH(W)) eng1 (.a(e1_a), .b(e1_b), .opcode(e1_op), .result(e1_res));

  logic_cmd_issuer #(.WIDTH(W), .FIFO_DEPTH(4), .ENG_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_a(c3_a), .cmd_b(c3_b), .cmd_opcode(c3_op), .cmd_chain(c3_chain),
    .eng_a(e3_a), .eng_b(e3_b), .eng_opcode(e3_op), .eng_result(e3_res),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_data(r3_data),
    .rsp_opcode(r3_op), .busy(busy3));
  logic_engine #(.WIDTH(W)) eng3 (.a(e3_a), .b(e3_b), .opcode(e3_op), .result(e3_comb));

  // slow engine: result only settles three cycles after its inputs change
  always @(posedge clk) begin
    pipe3  <= e3_comb;
    e3_res <= pipe3;
  end

  int           checks = 0;
  int           errors = 0;
  logic [9:0]   q1[$];
  logic [9:0]   q3[$];
  logic [W-1:0] acc1, acc3;
  logic [9:0]   e1w, e3w;
  int           n1 = 0;
  int           n3 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return ~(a & b);
      2'b10:   return ~(a | b);
      default: return a & b;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst && r1_valid && r1_ready) begin
      n1++;
      check("rsp1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1w = q1.pop_front();
        check("rsp1_data", 32'(r1_data), 32'(e1w[7:0]));
        check("rsp1_op", 32'(r1_op), 32'(e1w[9:8]));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && r3_valid && r3_ready) begin
      n3++;
      check("rsp3_expected", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e3w = q3.pop_front();
        check("rsp3_data", 32'(r3_data), 32'(e3w[7:0]));
        check("rsp3_op", 32'(r3_op), 32'(e3w[9:8]));
      end
    end
  end

  task automatic send(input bit d3, input logic ch, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    logic [W-1:0] r;
    ok = 1'b0;
    if (d3) begin
      c3_valid = 1'b1; c3_chain = ch; c3_op = op; c3_a = a; c3_b = b;
    end else begin
      c1_valid = 1'b1; c1_chain = ch; c1_op = op; c1_a = a; c1_b = b;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d3 ? c3_ready : c1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (d3) c3_valid = 1'b0;
    else c1_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      if (d3) begin
        r = ref_op(op, ch ? acc3 : a, b); acc3 = r; q3.push_back({op, r});
      end else begin
        r = ref_op(op, ch ? acc1 : a, b); acc1 = r; q1.push_back({op, r});
      end
    end
  endtask

  task automatic wait_rsp(input bit d3, output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (d3 ? r3_valid : r1_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q1.delete(); q3.delete();
    acc1 = '0; acc3 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] t1a[4] = '{8'hAA, 8'hF0, 8'hAA, 8'hF0};
  logic [W-1:0] t1b[4] = '{8'h55, 8'h0F, 8'h55, 8'hCC};
  logic [1:0]   t1o[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [W-1:0] t1x[4] = '{8'hFF, 8'hFF, 8'h00, 8'hC0};
  logic [W-1:0] t5a[4] = '{8'hAA, 8'hF0, 8'h0F, 8'h33};
  logic [W-1:0] t5b[4] = '{8'h55, 8'hCC, 8'hF0, 8'h0F};
  logic [1:0]   t5o[4] = '{2'b00, 2'b11, 2'b10, 2'b01};

  int lat, n0, gap;
  bit tog_stop;

  initial begin
    rst = 1'b1;
    c1_valid = 1'b0; c1_chain = 1'b0; c1_op = 2'b00; c1_a = '0; c1_b = '0; r1_ready = 1'b1;
    c3_valid = 1'b0; c3_chain = 1'b0; c3_op = 2'b00; c3_a = '0; c3_b = '0; r3_ready = 1'b1;
    acc1 = '0; acc3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(c1_ready), 32'd0);
    check("rst_rsp_valid", 32'(r1_valid), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_eng_a", 32'(e1_a), 32'd0);
    check("rst_rsp_data", 32'(r1_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(c1_ready), 32'd1);

    // single operations, ENG_LAT=1
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b0, t1o[i], t1a[i], t1b[i]);
      wait_rsp(1'b0, lat);
      check("t1_lat", 32'(lat), 32'd2);
      check("t1_data", 32'(r1_data), 32'(t1x[i]));
      check("t1_op", 32'(r1_op), 32'(t1o[i]));
    end

    // chaining through the accumulator
    send(1'b0, 1'b0, OP_AND, 8'hF0, 8'hCC);
    wait_rsp(1'b0, lat); check("t2_and", 32'(r1_data), 32'hC0);
    send(1'b0, 1'b1, OP_OR, 8'h5A, 8'h0F);
    wait_rsp(1'b0, lat); check("t2_chain_or", 32'(r1_data), 32'hCF);
    send(1'b0, 1'b1, OP_NOR, 8'h5A, 8'hFF);
    wait_rsp(1'b0, lat); check("t2_chain_nor", 32'(r1_data), 32'h00);
    @(posedge clk); #1;
    do_reset();
    send(1'b0, 1'b1, OP_OR, 8'h5A, 8'h3C);
    wait_rsp(1'b0, lat); check("t2_chain_after_rst", 32'(r1_data), 32'h3C);
    @(posedge clk); #1;

    // full FIFO with response stalled
    r1_ready = 1'b0;
    n0 = n1;
    for (int i = 0; i < 5; i++)
      send(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    c1_valid = 1'b1; c1_a = 8'h11; c1_b = 8'h22; c1_op = 2'b00; c1_chain = 1'b0;
    @(negedge clk);
    check("t3_full_ready", 32'(c1_ready), 32'd0);
    check("t3_busy", 32'(busy1), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(r1_valid), 32'd1);
      check("t3_hold_data", 32'(r1_data), 32'(q1[0][7:0]));
      check("t3_hold_op", 32'(r1_op), 32'(q1[0][9:8]));
      check("t3_still_full", 32'(c1_ready), 32'd0);
    end
    @(posedge clk); #1;
    c1_valid = 1'b0;
    r1_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (q1.size() == 0 && !busy1) break;
    end
    check("t3_rsp_count", 32'(n1 - n0), 32'd5);
    check("t3_drained", 32'(q1.size()), 32'd0);

    // random commands with toggling back-pressure
    n0 = n1;
    tog_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          send(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
        end
        for (int k = 0; k < 600; k++) begin
          @(posedge clk); #1;
          if (q1.size() == 0 && !busy1) break;
        end
        tog_stop = 1'b1;
      end
      begin
        while (!tog_stop) begin
          @(posedge clk); #1;
          r1_ready = ~r1_ready;
        end
      end
    join
    r1_ready = 1'b1;
    check("t4_rsp_count", 32'(n1 - n0), 32'd50);
    check("t4_drained", 32'(q1.size()), 32'd0);

    // slow engine, ENG_LAT=3
    for (int i = 0; i < 12; i++) begin
      if (i < 4) send(1'b1, 1'b0, t5o[i], t5a[i], t5b[i]);
      else send(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      wait_rsp(1'b1, lat);
      check("t5_lat", 32'(lat), 32'd4);
    end
    @(posedge clk); #1;

    // reset while waiting on the engine with two commands buffered
    send(1'b1, 1'b0, OP_AND, 8'hF0, 8'h3C);
    send(1'b1, 1'b0, OP_OR, 8'h01, 8'h02);
    send(1'b1, 1'b0, OP_NOR, 8'h01, 8'h02);
    check("t6_busy_before", 32'(busy3), 32'd1);
    rst = 1'b1;
    q1.delete(); q3.delete(); acc1 = '0; acc3 = '0;
    n0 = n3;
    @(posedge clk); #1;
    check("t6_rsp_valid", 32'(r3_valid), 32'd0);
    check("t6_busy", 32'(busy3), 32'd0);
    check("t6_ready_in_rst", 32'(c3_ready), 32'd0);
    check("t6_eng_a", 32'(e3_a), 32'd0);
    check("t6_eng_b", 32'(e3_b), 32'd0);
    check("t6_eng_op", 32'(e3_op), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", 32'(c3_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_stale", 32'(n3 - n0), 32'd0);
    send(1'b1, 1'b1, OP_OR, 8'hAA, 8'h3C);
    wait_rsp(1'b1, lat);
    check("t6_after_lat", 32'(lat), 32'd4);
    check("t6_after_data", 32'(r3_data), 32'h3C);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
